// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: per-frame threshold, binary or saturated-magnitude
// output, border zeroing and a fixed 4-cycle pixel-to-result latency.
module sobel_edge_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 200,
  parameter int IMG_HEIGHT = 200
) (
  input  logic                  clk,
  input  logic                  rst_p,
  input  logic                  gray_valid,
  input  logic                  gray_hsync,
  input  logic                  gray_vsync,
  input  logic [DATA_WIDTH-1:0] gray,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic                  mode,
  output logic                  edge_valid,
  output logic                  edge_hsync,
  output logic                  edge_vsync,
  output logic [DATA_WIDTH-1:0] edge_data,
  output logic                  edge_bin,
  output logic                  frame_done
);

  localparam int GW = DATA_WIDTH + 3;
  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [GW-1:0] PIX_MAX  = GW'((2 ** DATA_WIDTH) - 1);

  function automatic logic signed [GW-1:0] widen(input logic [DATA_WIDTH-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] v);
    return v[GW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  logic                  accept_s;
  logic                  frame_start_s;
  logic                  border_s;
  logic                  last_s;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] thr_q, thr_d;

  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];
  // win_q[r][c]: r=0 is row-2, r=2 the current row; c=2 is the newest column
  logic [2:0][2:0][DATA_WIDTH-1:0] win_q, win_d;

  logic                  s1_valid_q, s1_hsync_q, s1_vsync_q, s1_border_q, s1_last_q;
  logic [DATA_WIDTH-1:0] s1_thr_q;
  logic                  s2_valid_q, s2_hsync_q, s2_vsync_q, s2_border_q, s2_last_q;
  logic [DATA_WIDTH-1:0] s2_thr_q;
  logic signed [GW-1:0]  s2_gx_q, s2_gy_q, gx_d, gy_d;
  logic                  s3_valid_q, s3_hsync_q, s3_vsync_q, s3_last_q;
  logic [DATA_WIDTH-1:0] s3_thr_q;
  logic [GW-1:0]         s3_mag_q, mag_d;

  logic [DATA_WIDTH-1:0] sat_s;
  logic [DATA_WIDTH-1:0] edge_data_d;
  logic                  edge_bin_d;
  logic                  frame_done_d;

  // Position counters, per-frame threshold latch and per-pixel border/last flags
  always_comb begin
    accept_s = gray_valid & gray_vsync;
    col_d    = col_q;
    row_d    = row_q;
    if (!gray_vsync) begin
      col_d = '0;
      row_d = '0;
    end else if (gray_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
    end
    frame_start_s = accept_s && (col_q == '0) && (row_q == '0);
    thr_d         = frame_start_s ? threshold : thr_q;
    // Non-accepted cycles are treated as border so they can never produce a non-zero result
    border_s      = !accept_s || (col_q < CW'(2)) || (row_q < RW'(2));
    last_s        = accept_s && (col_q == COL_LAST) && (row_q == ROW_LAST);
  end

  // Window shift: new right column is {row-2, row-1, row} taken from the line buffers
  always_comb begin
    win_d = win_q;
    if (accept_s) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_q[col_q];
      win_d[1][2] = lb1_q[col_q];
      win_d[2][2] = gray;
    end else begin
      win_d = win_q;
    end
  end

  // Gradient, magnitude and output formatting for stages 2..4
  always_comb begin
    gx_d = (widen(win_q[0][2]) + (widen(win_q[1][2]) <<< 1) + widen(win_q[2][2]))
         - (widen(win_q[0][0]) + (widen(win_q[1][0]) <<< 1) + widen(win_q[2][0]));
    gy_d = (widen(win_q[2][0]) + (widen(win_q[2][1]) <<< 1) + widen(win_q[2][2]))
         - (widen(win_q[0][0]) + (widen(win_q[0][1]) <<< 1) + widen(win_q[0][2]));
    mag_d = s2_border_q ? '0 : (abs_val(s2_gx_q) + abs_val(s2_gy_q));
    edge_bin_d = s3_valid_q && (s3_mag_q > {3'b000, s3_thr_q});
    sat_s = (s3_mag_q > PIX_MAX) ? PIX_MAX[DATA_WIDTH-1:0] : s3_mag_q[DATA_WIDTH-1:0];
    if (!s3_valid_q) begin
      edge_data_d = '0;
    end else if (mode) begin
      edge_data_d = sat_s;
    end else begin
      edge_data_d = {DATA_WIDTH{edge_bin_d}};
    end
    frame_done_d = s3_valid_q && s3_last_q;
  end

  // Line buffers: lb1 holds row-1 and lb2 holds row-2 at the current column
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
    end else if (accept_s) begin
      lb1_q[col_q] <= gray;
      lb2_q[col_q] <= lb1_q[col_q];
    end
  end

  // Counters, window and the four pipeline stages
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      col_q       <= '0;
      row_q       <= '0;
      thr_q       <= '0;
      win_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_hsync_q  <= 1'b0;
      s1_vsync_q  <= 1'b0;
      s1_border_q <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_thr_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_hsync_q  <= 1'b0;
      s2_vsync_q  <= 1'b0;
      s2_border_q <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_thr_q    <= '0;
      s2_gx_q     <= '0;
      s2_gy_q     <= '0;
      s3_valid_q  <= 1'b0;
      s3_hsync_q  <= 1'b0;
      s3_vsync_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_thr_q    <= '0;
      s3_mag_q    <= '0;
      edge_valid  <= 1'b0;
      edge_hsync  <= 1'b0;
      edge_vsync  <= 1'b0;
      edge_data   <= '0;
      edge_bin    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      thr_q       <= thr_d;
      win_q       <= win_d;
      // The threshold travels with each pixel so a new frame cannot retarget the tail of the old one
      s1_valid_q  <= gray_valid;
      s1_hsync_q  <= gray_hsync;
      s1_vsync_q  <= gray_vsync;
      s1_border_q <= border_s;
      s1_last_q   <= last_s;
      s1_thr_q    <= thr_d;
      s2_valid_q  <= s1_valid_q;
      s2_hsync_q  <= s1_hsync_q;
      s2_vsync_q  <= s1_vsync_q;
      s2_border_q <= s1_border_q;
      s2_last_q   <= s1_last_q;
      s2_thr_q    <= s1_thr_q;
      s2_gx_q     <= gx_d;
      s2_gy_q     <= gy_d;
      s3_valid_q  <= s2_valid_q;
      s3_hsync_q  <= s2_hsync_q;
      s3_vsync_q  <= s2_vsync_q;
      s3_last_q   <= s2_last_q;
      s3_thr_q    <= s2_thr_q;
      s3_mag_q    <= mag_d;
      edge_valid  <= s3_valid_q;
      edge_hsync  <= s3_hsync_q;
      edge_vsync  <= s3_vsync_q;
      edge_data   <= edge_data_d;
      edge_bin    <= edge_bin_d;
      frame_done  <= frame_done_d;
    end
  end

endmodule
